// File: rtl/scaler_pixel_blend.sv
// scaler_pixel_blend: horizontal linear blender between line buffer/interpolator and video mux
//  clk, reset_n      clock, asynchronous active-low reset
//  line_start        re-prime on a new source line (wins over frac_ce)
//  frac_ce           interpolator outputs valid: step, fraction, blank
//  nearest           force blend weight to 0
//  src_addr/src_pix  line-buffer read address / {r,g,b} at that address
//  out_pix/out_valid blended pixel, valid pulse 3 cycles after an accepted frac_ce
module scaler_pixel_blend #(
  parameter int COLBITS   = 6,
  parameter int ADDRBITS  = 10,
  parameter int FRACWIDTH = 16,
  parameter int WBITS     = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_start,
  input  logic                   frac_ce,
  input  logic                   step,
  input  logic [FRACWIDTH-1:0]   fraction,
  input  logic                   blank,
  input  logic                   nearest,
  output logic [ADDRBITS-1:0]    src_addr,
  input  logic [3*COLBITS-1:0]   src_pix,
  output logic [3*COLBITS-1:0]   out_pix,
  output logic                   out_valid
);
  localparam int PW = COLBITS + WBITS + 1;
  localparam logic [WBITS:0] FULL = (WBITS+1)'(1) << WBITS;
  localparam logic [PW-1:0] HALF = PW'(1) << (WBITS - 1);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [3*COLBITS-1:0] prev_q, prev_d, cur_q, cur_d;
  logic accept;
  logic v1_q, v1_d, b1_q, b1_d, v2_q, v2_d, b2_q, b2_d, out_valid_q, out_valid_d;
  logic [WBITS-1:0] w1_q, w1_d;
  logic [WBITS:0] inv_w;
  logic [3*COLBITS-1:0] p1_q, p1_d, c1_q, c1_d, out_pix_q, out_pix_d;
  logic [2:0][PW-1:0] pc2_q, pc2_d, pp2_q, pp2_d;
  logic unused_frac;
  assign unused_frac = ^fraction;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    accept  = frac_ce && !line_start && state_q != IDLE;
    if (line_start) begin
      state_d = PRIME;
      addr_d  = '0;
    end else if (accept && state_q == PRIME) begin
      state_d = RUN;
      prev_d  = src_pix;
      cur_d   = src_pix;
      addr_d  = ADDRBITS'(1);
    end else if (accept && step) begin
      prev_d = cur_q;
      cur_d  = src_pix;
      addr_d = addr_q + 1'b1;
    end
  end
  // S1 takes the post-update prev/cur so the blend reflects this frac_ce's step
  always_comb begin
    v1_d = accept;
    b1_d = blank;
    w1_d = nearest ? '0 : fraction[FRACWIDTH-1 -: WBITS];
    p1_d = prev_d;
    c1_d = cur_d;
  end
  always_comb begin
    inv_w = FULL - {1'b0, w1_q};
    v2_d  = v1_q;
    b2_d  = b1_q;
    for (int c = 0; c < 3; c++) begin
      pc2_d[c] = PW'(c1_q[c*COLBITS +: COLBITS]) * PW'(inv_w);
      pp2_d[c] = PW'(p1_q[c*COLBITS +: COLBITS]) * PW'(w1_q);
    end
  end
  // the rounded sum never exceeds the channel maximum, so truncation is exact
  always_comb begin
    out_valid_d = v2_q;
    out_pix_d   = out_pix_q;
    for (int c = 0; c < 3; c++)
      if (v2_q) out_pix_d[c*COLBITS +: COLBITS] = b2_q ? '0 : COLBITS'((pc2_q[c] + pp2_q[c] + HALF) >> WBITS);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      v1_q        <= 1'b0;
      b1_q        <= 1'b0;
      w1_q        <= '0;
      p1_q        <= '0;
      c1_q        <= '0;
      v2_q        <= 1'b0;
      b2_q        <= 1'b0;
      pc2_q       <= '0;
      pp2_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      v1_q        <= v1_d;
      b1_q        <= b1_d;
      w1_q        <= w1_d;
      p1_q        <= p1_d;
      c1_q        <= c1_d;
      v2_q        <= v2_d;
      b2_q        <= b2_d;
      pc2_q       <= pc2_d;
      pp2_q       <= pp2_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
    end
  end
  assign src_addr  = addr_q;
  assign out_pix   = out_pix_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_scaler_pixel_blend.sv
// tb_scaler_pixel_blend: vector table plus scoreboard for scaler_pixel_blend
module tb_scaler_pixel_blend;
  logic clk = 1'b0, reset_n = 1'b0;
  logic line_start = 0, frac_ce = 0, step = 0, blank = 0, nearest = 0;
  logic [15:0] fraction = '0;
  logic [17:0] src_pix = '0, out_pix;
  logic [9:0] src_addr;
  logic out_valid;
  int tests = 0, fails = 0;
  logic [17:0] sb[$];
  typedef struct {
    logic ls, ce, st, bl, nr;
    logic [15:0] fr;
    logic [17:0] sp;
    logic [9:0] ea;
    logic ev;
    logic [17:0] ep;
  } vec_t;
  vec_t tab[$];
  scaler_pixel_blend dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .frac_ce(frac_ce), .step(step),
    .fraction(fraction), .blank(blank), .nearest(nearest), .src_addr(src_addr),
    .src_pix(src_pix), .out_pix(out_pix), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [17:0] px(int r, int g, int b);
    return {6'(r), 6'(g), 6'(b)};
  endfunction
  function automatic logic [17:0] gy(int v);
    return px(v, v, v);
  endfunction
  function automatic vec_t mk(logic ls, logic ce, logic st, logic [15:0] fr, logic bl, logic nr,
                              logic [17:0] sp, int ea, logic ev, logic [17:0] ep);
    vec_t v;
    v.ls = ls; v.ce = ce; v.st = st; v.fr = fr; v.bl = bl; v.nr = nr;
    v.sp = sp; v.ea = 10'(ea); v.ev = ev; v.ep = ep;
    return v;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(vec_t v, int idx);
    line_start = v.ls; frac_ce = v.ce; step = v.st; fraction = v.fr;
    blank = v.bl; nearest = v.nr; src_pix = v.sp;
    if (v.ev) sb.push_back(v.ep);
    @(posedge clk);
    #1;
    check($sformatf("src_addr[%0d]", idx), 32'(src_addr), 32'(v.ea));
    line_start = 0; frac_ce = 0; step = 0;
  endtask
  always @(negedge clk)
    if (reset_n && out_valid) begin
      if (sb.size() == 0) check("unexpected out_valid", 1, 0);
      else check("out_pix", 32'(out_pix), 32'(sb.pop_front()));
    end
  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(9),        0,0,0));
    tab.push_back(mk(1,0,0,16'h0000,0,0,gy(0),        0,0,0));
    tab.push_back(mk(0,1,1,16'h8000,0,0,px(10,20,30), 1,1,px(10,20,30)));
    tab.push_back(mk(1,0,0,16'h0000,0,0,gy(0),        0,0,0));
    tab.push_back(mk(0,1,0,16'h0000,0,0,gy(0),        1,1,gy(0)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(63),       2,1,gy(63)));
    tab.push_back(mk(0,1,0,16'h8000,0,0,gy(1),        2,1,gy(32)));
    tab.push_back(mk(0,1,0,16'hF000,0,0,gy(1),        2,1,gy(4)));
    tab.push_back(mk(0,1,0,16'h0000,0,0,gy(1),        2,1,gy(63)));
    tab.push_back(mk(0,0,1,16'h8000,0,0,gy(1),        2,0,0));
    tab.push_back(mk(0,1,1,16'h8000,1,0,gy(20),       3,1,gy(0)));
    tab.push_back(mk(0,1,0,16'hFFFF,0,1,gy(7),        3,1,gy(20)));
    tab.push_back(mk(0,1,1,16'h4000,0,0,px(40,0,63),  4,1,px(35,5,52)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(5),        5,1,gy(5)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(40),       6,1,gy(40)));
    tab.push_back(mk(1,1,1,16'h0000,0,0,gy(9),        0,0,0));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(7),        1,1,gy(7)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(1),        2,1,gy(1)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(2),        3,1,gy(2)));
    tab.push_back(mk(0,1,1,16'h0000,0,0,gy(3),        4,1,gy(3)));
    #2;
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_pix", 32'(out_pix), 0);
    check("reset src_addr", 32'(src_addr), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    foreach (tab[i]) drive(tab[i], i);
    for (int a = 5; a <= 1023; a++)
      drive(mk(0,1,1,16'h0000,0,0,gy((a % 62) + 1),a,1,gy((a % 62) + 1)), 100 + a);
    drive(mk(0,1,1,16'h0000,0,0,gy(33),0,1,gy(33)), 2000);
    frac_ce = 1; step = 1; src_pix = gy(17);
    #2 reset_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 0);
    check("async out_pix", 32'(out_pix), 0);
    check("async src_addr", 32'(src_addr), 0);
    sb.delete();
    frac_ce = 0; step = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(mk(0,1,1,16'h0000,0,0,gy(11),0,0,0), 3000);
    repeat (6) @(posedge clk);
    #1 check("scoreboard drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
